// File: rtl/instr_sequencer.sv
// Instruction sequencer: a small loadable program memory plus a program counter.
// Once started it issues one registered instruction per cycle and stops on HALT.
module instr_sequencer #(
   parameter int unsigned            INSTR_WIDTH = 20,
   parameter int unsigned            PC_BITS     = 5,
   parameter logic [3:0]             HALT_OPCODE = 4'hF,
   parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
   parameter int unsigned            CNT_BITS    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   load_en_i,
   input  logic [PC_BITS-1:0]     load_addr_i,
   input  logic [INSTR_WIDTH-1:0] load_data_i,
   input  logic                   start_i,
   input  logic                   stall_i,
   output logic [INSTR_WIDTH-1:0] instruction_o,
   output logic [PC_BITS-1:0]     pc_o,
   output logic                   running_o,
   output logic                   halted_o,
   output logic [CNT_BITS-1:0]    issued_cnt_o
);

   localparam int unsigned Depth = 2 ** PC_BITS;

   typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

   state_e                 state_q, state_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [INSTR_WIDTH-1:0] mem_q [Depth];

   logic [INSTR_WIDTH-1:0] fetch_word;
   logic                   fetch_is_halt;
   logic                   mem_we;

   assign fetch_word    = mem_q[pc_q];
   assign fetch_is_halt = (fetch_word[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
   // Memory is frozen while executing; reset overrides a coincident write.
   assign mem_we        = load_en_i && (state_q != StRun) && !rst_i;

   // Program memory write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[load_addr_i] <= load_data_i;
      end
   end

   // Next-state logic: sequencing, issue and counter update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      instr_d = NOP_WORD;
      unique case (state_q)
         StIdle, StHalted: begin
            if (start_i) begin
               state_d = StRun;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (!stall_i) begin
               if (fetch_is_halt) begin
                  // HALT word is not issued; pc stays pointing at it.
                  state_d = StHalted;
               end else begin
                  instr_d = fetch_word;
                  pc_d    = pc_q + 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
         instr_q <= NOP_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
      end
   end

   assign instruction_o = instr_q;
   assign pc_o          = pc_q;
   assign issued_cnt_o  = cnt_q;
   assign running_o     = (state_q == StRun);
   assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: load, run, stall, halt, wrap, saturate, reset.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [19:0] load_data;
   logic        start;
   logic        stall;
   logic [19:0] instruction;
   logic [4:0]  pc;
   logic        running;
   logic        halted;
   logic [7:0]  issued_cnt;

   int checks = 0;
   int errors = 0;

   instr_sequencer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .load_en_i     (load_en),
      .load_addr_i   (load_addr),
      .load_data_i   (load_data),
      .start_i       (start),
      .stall_i       (stall),
      .instruction_o (instruction),
      .pc_o          (pc),
      .running_o     (running),
      .halted_o      (halted),
      .issued_cnt_o  (issued_cnt)
   );

   always #5 clk = ~clk;

   // Advance one edge; sample 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [4:0] a, input logic [19:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; stall = 1'b0;

      // 1: reset
      tick(); tick();
      check("rst_instr",   32'(instruction), 32'h0);
      check("rst_pc",      32'(pc), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_halted",  32'(halted), 32'h0);
      check("rst_cnt",     32'(issued_cnt), 32'h0);
      rst = 1'b0;

      // 2: short program ending in HALT
      load_word(5'd0, 20'h1_0203);
      load_word(5'd1, 20'h2_0405);
      load_word(5'd2, 20'hF_0000);
      start = 1'b1; tick(); start = 1'b0;
      check("start_running", 32'(running), 32'h1);
      check("start_instr",   32'(instruction), 32'h0);
      check("start_pc",      32'(pc), 32'h0);
      tick();
      check("p_issue0", 32'(instruction), 32'h1_0203);
      check("p_pc1",    32'(pc), 32'h1);
      check("p_cnt1",   32'(issued_cnt), 32'h1);
      tick();
      check("p_issue1", 32'(instruction), 32'h2_0405);
      check("p_pc2",    32'(pc), 32'h2);
      tick();
      check("halt_instr",   32'(instruction), 32'h0);
      check("halt_halted",  32'(halted), 32'h1);
      check("halt_running", 32'(running), 32'h0);
      check("halt_pc",      32'(pc), 32'h2);
      check("halt_cnt",     32'(issued_cnt), 32'h2);
      tick();
      check("halt_hold_instr", 32'(instruction), 32'h0);
      check("halt_hold_pc",    32'(pc), 32'h2);

      // 3: stall after first issue
      start = 1'b1; tick(); start = 1'b0;
      check("restart_cnt", 32'(issued_cnt), 32'h0);
      tick();
      check("s_issue0", 32'(instruction), 32'h1_0203);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", 32'(instruction), 32'h0);
         check("stall_pc",    32'(pc), 32'h1);
         check("stall_cnt",   32'(issued_cnt), 32'h1);
      end
      stall = 1'b0;
      tick();
      check("resume_instr", 32'(instruction), 32'h2_0405);
      check("resume_pc",    32'(pc), 32'h2);
      tick();
      check("s_halted", 32'(halted), 32'h1);

      // 5: load attempt during RUN is ignored
      start = 1'b1; tick(); start = 1'b0;
      load_en = 1'b1; load_addr = 5'd1; load_data = 20'hF_0000;
      tick();
      load_en = 1'b0;
      check("l_issue0", 32'(instruction), 32'h1_0203);
      tick();
      check("l_issue1", 32'(instruction), 32'h2_0405);
      check("l_running", 32'(running), 32'h1);
      tick();
      check("l_halted", 32'(halted), 32'h1);

      // 4: 32 non-HALT words, wrap and counting
      for (int i = 0; i < 32; i++) load_word(5'(i), 20'h3_0000 | 20'(i));
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         check("w_instr", 32'(instruction), 32'h3_0000 | 32'(k % 32));
         check("w_pc",    32'(pc), 32'((k + 1) % 32));
      end
      check("w_cnt40", 32'(issued_cnt), 32'd40);
      check("w_running", 32'(running), 32'h1);

      // Saturation of the issue counter
      for (int k = 0; k < 230; k++) tick();
      check("sat_cnt", 32'(issued_cnt), 32'd255);
      check("sat_pc",  32'(pc), 32'(270 % 32));

      // 6: reset mid-RUN, memory retained
      rst = 1'b1; tick(); rst = 1'b0;
      check("mr_instr",   32'(instruction), 32'h0);
      check("mr_running", 32'(running), 32'h0);
      check("mr_pc",      32'(pc), 32'h0);
      check("mr_cnt",     32'(issued_cnt), 32'h0);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("mr_issue0", 32'(instruction), 32'h3_0000);
      tick();
      check("mr_issue1", 32'(instruction), 32'h3_0001);

      // Load and start on the same edge from IDLE
      rst = 1'b1; tick(); rst = 1'b0;
      load_en = 1'b1; load_addr = 5'd0; load_data = 20'h5_5555; start = 1'b1;
      tick();
      load_en = 1'b0; start = 1'b0;
      check("ls_running", 32'(running), 32'h1);
      tick();
      check("ls_issue0", 32'(instruction), 32'h5_5555);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
